// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO with occupancy flags.
// Pointer and count widths are derived from DEPTH here.
package sync_fifo_pkg;

    localparam int unsigned DefaultWidth = 128;
    localparam int unsigned DefaultDepth = 1024;

    // Occupancy flags bundled so they are derived together from one count.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are never reset; the pointer logic decides what is valid.
module fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned ADDR = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDR-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ADDR-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with full/empty/almost flags, live count and sticky error flags.
// Supports registered-read (FWFT=0) and first-word-fall-through (FWFT=1) output modes.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned DEPTH    = DefaultDepth,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 2,
    parameter bit          FWFT     = 1'b0,
    localparam int unsigned ADDR    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ADDR:0] FullCount = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR:0] AfCount   = (ADDR + 1)'(AF_LEVEL);
    localparam logic [ADDR:0] AeCount   = (ADDR + 1)'(AE_LEVEL);

    logic [ADDR:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] ram_rdata;
    fifo_flags_t      flags;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        flags              = '0;
        flags.full         = (count == FullCount);
        flags.empty        = (count == '0);
        flags.almost_full  = (count >= AfCount);
        flags.almost_empty = (count <= AeCount);
    end

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;

    // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it.
    assign rd_acc = rd & ~flags.empty;
    assign wr_acc = wr & (~flags.full | rd);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd && !rd_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~clear),
        .waddr (wr_ptr_q[ADDR-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_q[ADDR-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT) begin : g_fwft
        assign data_out = ram_rdata;
    end else begin : g_registered
        logic [WIDTH-1:0] data_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
            end else if (clear) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= ram_rdata;
            end
        end

        assign data_out = data_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: registered and FWFT instances share stimulus and are
// compared every cycle against a queue-based model, plus directed literal checks.
module tb_sync_fifo_flags;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned AF = 12;
    localparam int unsigned AE = 2;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic         clear   = 1'b0;
    logic         wr      = 1'b0;
    logic         rd      = 1'b0;
    logic [W-1:0] data_in = '0;

    logic [W-1:0] dout0, dout1;
    logic         full0, empty0, af0, ae0, ovf0, udf0;
    logic         full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0]   count0, count1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: contents as a queue, plus the sticky flags and registered output.
    logic [W-1:0] q[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;
    logic [W-1:0] m_dout = '0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE),
        .FWFT     (1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (dout0),
        .full         (full0),
        .empty        (empty0),
        .almost_full  (af0),
        .almost_empty (ae0),
        .count        (count0),
        .overflow     (ovf0),
        .underflow    (udf0)
    );

    sync_fifo_flags #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE),
        .FWFT     (1'b1)
    ) dut_fwft (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (dout1),
        .full         (full1),
        .empty        (empty1),
        .almost_full  (af1),
        .almost_empty (ae1),
        .count        (count1),
        .overflow     (ovf1),
        .underflow    (udf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;
    endtask

    task automatic model_edge(input bit w, input logic [W-1:0] d, input bit r, input bit c);
        bit ra, wa;
        if (c) begin
            model_reset();
        end else begin
            ra = r && (q.size() != 0);
            wa = w && ((q.size() < D) || r);
            if (w && !wa) m_ovf = 1'b1;
            if (r && !ra) m_udf = 1'b1;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(d);
        end
    endtask

    // Inputs change 1 time unit after the edge; the task returns with outputs settled.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c);
        wr      = w;
        data_in = d;
        rd      = r;
        clear   = c;
        @(posedge clk);
        model_edge(w, d, r, c);
        #1;
        wr    = 1'b0;
        rd    = 1'b0;
        clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count0), 32'(q.size()));
            chk("full", 32'(full0), 32'(q.size() == D));
            chk("empty", 32'(empty0), 32'(q.size() == 0));
            chk("almost_full", 32'(af0), 32'(q.size() >= AF));
            chk("almost_empty", 32'(ae0), 32'(q.size() <= AE));
            chk("overflow", 32'(ovf0), 32'(m_ovf));
            chk("underflow", 32'(udf0), 32'(m_udf));
            chk("data_out_reg", 32'(dout0), 32'(m_dout));
            chk("count_fwft", 32'(count1), 32'(q.size()));
            chk("empty_fwft", 32'(empty1), 32'(q.size() == 0));
            if (q.size() != 0) begin
                chk("data_out_fwft", 32'(dout1), 32'(q[0]));
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        int pw, pr;

        // Reset state
        #2 reset_n = 1'b0;
        model_reset();
        #2;
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_almost_empty", 32'(ae0), 32'd1);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_almost_full", 32'(af0), 32'd0);
        chk("rst_overflow", 32'(ovf0), 32'd0);
        chk("rst_data_out", 32'(dout0), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Fill: almost_full at 12, full at 16, 17th write rejected
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0);
            if (i == 11) chk("af_at_11", 32'(af0), 32'd0);
            if (i == 12) chk("af_at_12", 32'(af0), 32'd1);
            if (i == 15) chk("full_at_15", 32'(full0), 32'd0);
        end
        chk("full_at_16", 32'(full0), 32'd1);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_17th", 32'(ovf0), 32'd1);
        chk("count_17th", 32'(count0), 32'd16);

        // Drain in order with one-cycle latency; extra read underflows
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_data", 32'(dout0), 32'(i));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("udf_17th", 32'(udf0), 32'd1);
        chk("empty_17th", 32'(empty0), 32'd1);
        chk("hold_17th", 32'(dout0), 32'h10);

        // Clear, then simultaneous read/write while full
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clear_ovf", 32'(ovf0), 32'd0);
        for (int i = 1; i <= 16; i++) step(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0);
        chk("rw_full_count", 32'(count0), 32'd16);
        chk("rw_full_full", 32'(full0), 32'd1);
        chk("rw_full_data", 32'(dout0), 32'h21);
        chk("rw_full_ovf", 32'(ovf0), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("rw_full_last", 32'(dout0), 32'h99);

        // Interleaved pairs across the pointer wrap
        for (int i = 0; i < 40; i++) begin
            v = W'(i * 7 + 3);
            step(1'b1, v, 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
            chk("wrap_data", 32'(dout0), 32'(v));
            chk("wrap_count_le16", 32'(count0 <= 5'd16), 32'd1);
        end

        // First-word-fall-through presents the word without a read
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_empty", 32'(empty1), 32'd0);
        chk("fwft_data", 32'(dout1), 32'h5A);

        // Randomized phases biasing towards fill, drain, balance and saturation
        for (int ph = 0; ph < 4; ph++) begin
            pw = (ph == 0) ? 75 : (ph == 1) ? 25 : (ph == 2) ? 50 : 90;
            pr = (ph == 0) ? 25 : (ph == 1) ? 75 : (ph == 2) ? 50 : 90;
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(0, 99) < pw, W'($urandom), $urandom_range(0, 99) < pr,
                     $urandom_range(0, 63) == 0);
            end
        end

        // Async reset with count 7 and overflow set
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(count0), 32'd7);
        chk("pre_rst_ovf", 32'(ovf0), 32'd1);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_count", 32'(count0), 32'd0);
        chk("mid_rst_empty", 32'(empty0), 32'd1);
        chk("mid_rst_ovf", 32'(ovf0), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst_fwft", 32'(dout1), 32'h77);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_data", 32'(dout0), 32'h77);

        // Clear with count 5
        for (int i = 0; i < 5; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        chk("pre_clear_count", 32'(count0), 32'd5);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("post_clear_count", 32'(count0), 32'd0);
        chk("post_clear_data", 32'(dout0), 32'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter WIDTH, default 128, data word width in bits.
REQ-002 Parameter DEPTH, default 1024, number of entries; SHALL be a power of two and at least 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-4, occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 Parameter FWFT, default 0; 0 = registered read mode, 1 = first-word-fall-through mode.
REQ-006 Derived constant ADDR = clog2(DEPTH); pointers and count are ADDR+1 bits wide.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 clear  input  1  synchronous flush, active-high.
REQ-010 wr  input  1  write request.
REQ-011 data_in  input  WIDTH  write data.
REQ-012 rd  input  1  read request.
REQ-013 data_out  output  WIDTH  read data.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-015 count  output  ADDR+1  current occupancy, range 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Read accepted (rd_acc) SHALL equal rd AND NOT empty.
REQ-018 Write accepted (wr_acc) SHALL equal wr AND (NOT full OR rd); simultaneous read and write when full SHALL both be accepted, count unchanged.
REQ-019 Simultaneous wr and rd when empty: write accepted, read rejected, count becomes 1, underflow set.
REQ-020 wr_ptr and rd_ptr SHALL be ADDR+1-bit counters incremented by 1 on wr_acc and rd_acc respectively, wrapping modulo 2^(ADDR+1); memory index is the low ADDR bits.
REQ-021 count SHALL equal wr_ptr - rd_ptr modulo 2^(ADDR+1); full = (count == DEPTH); empty = (count == 0).
REQ-022 almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL); all flags and count SHALL be combinational from the pointers and reflect each edge's update in the same cycle.
REQ-023 FWFT=0: on rd_acc, data_out SHALL load mem[rd_ptr] at that edge (one-cycle latency) and hold otherwise.
REQ-024 FWFT=1: data_out SHALL continuously present mem[rd_ptr]; valid whenever empty=0; rd_acc advances to the next word.
REQ-025 overflow SHALL set on the edge where wr=1 and wr_acc=0; underflow on the edge where rd=1 and rd_acc=0; both hold until clear or reset.
REQ-026 clear SHALL take priority over wr and rd: pointers 0, overflow/underflow 0, data_out 0 (FWFT=0); memory contents untouched.
REQ-027 Rejected writes SHALL not modify memory; rejected reads SHALL not modify data_out.

Reset
REQ-028 reset_n low SHALL immediately force wr_ptr=0, rd_ptr=0, data_out=0 (FWFT=0), overflow=0, underflow=0; hence count=0, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 Memory array SHALL NOT be reset.
REQ-030 Reset asserted mid-transfer SHALL discard all contents; the first write after release lands at index 0.

Structure
REQ-031 Package sync_fifo_pkg SHALL hold default WIDTH/DEPTH constants and the clog2-based ADDR helper.
REQ-032 Storage SHALL be a sub-module fifo_ram: simple dual-port, synchronous write, asynchronous read, parameterised by WIDTH and DEPTH; pointer, flag and output logic stay in sync_fifo_flags.

Verification (bench with WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=2)
REQ-033 Write 0x01..0x10 (16 words) -> almost_full at count 12, full at 16; 17th write 0xAA -> rejected, overflow=1, count stays 16.
REQ-034 From full, read 16 words, FWFT=0 -> data_out 0x01..0x10 in order, each one cycle after rd; 17th rd -> underflow=1, empty=1.
REQ-035 Full FIFO, wr=1 rd=1 same cycle -> both accepted, count stays 16, full stays 1, later reads return new word last.
REQ-036 Wrap: 40 interleaved write/read pairs across pointer wrap -> data order preserved, count never exceeds 16.
REQ-037 FWFT=1, write 0x5A to empty FIFO -> next cycle empty=0 and data_out=0x5A without rd.
REQ-038 Assert reset_n low with count=7 and overflow=1 -> count=0, empty=1, overflow=0 immediately; clear=1 with count=5 -> count=0 next edge.
